psdram_arbiter: RTL and testbench

Parametrised multi-channel arbiter and asynchronous-mode access sequencer for the Cellular RAM (PSDRAM). It replaces the button-toggled two-way mux in the top level with per-request round-robin arbitration, plus an optional real-time priority channel, so the VGA reader and UART writer can share the memory concurrently. It sits between the requesting modules and the top-level memory pins; the MemDB tri-state buffer stays in the top level, driven from `MemDB_out`/`MemDB_oe`.

---
 rtl/psdram_pkg.sv | 24 ++
 rtl/psdram_arbiter_rr_arbiter.sv | 33 +++
 rtl/psdram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_psdram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/psdram_pkg.sv
// Shared definitions for the PSDRAM arbiter: sequencer state encoding,
// default async-mode timing, and small sizing helpers.
package psdram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_RECOVER = 2'd3
   } psdram_state_e;

   localparam int PSDRAM_T_ACC_CYC = 7;
   localparam int PSDRAM_T_REC_CYC = 1;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/psdram_arbiter_rr_arbiter.sv
// Combinational round-robin picker with optional absolute priority for channel 0.
module rr_arbiter
   import psdram_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   input  logic          prio_en,
   output logic [N-1:0]  grant
);

   logic [N-1:0] w_mask;
   logic [N-1:0] w_hi;

   // Requests above last_grant win first; otherwise wrap to the lowest requester.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_mask[i] = (i > int'(last_grant));
      end
      w_hi = req & w_mask;
      if (prio_en && req[0]) begin
         grant = N'(1);
      end else if (w_hi != '0) begin
         grant = w_hi & (~w_hi + N'(1));
      end else begin
         grant = req & (~req + N'(1));
      end
   end

endmodule

// File: rtl/psdram_arbiter.sv
// Multi-channel arbiter and async-mode access sequencer for the Cellular RAM.
module psdram_arbiter
   import psdram_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int ADDR_W          = 23,
   parameter int DATA_W          = 16,
   parameter int ACCESS_CYCLES   = PSDRAM_T_ACC_CYC,
   parameter int RECOVERY_CYCLES = PSDRAM_T_REC_CYC,
   parameter int PRIO_EN         = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [2*NUM_CH-1:0]      be_n,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   output logic [NUM_CH-1:0]        ack,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic                     MemOE,
   output logic                     MemWR,
   output logic                     RamCE,
   output logic                     RamLB,
   output logic                     RamUB,
   output logic [ADDR_W-1:0]        MemAdr,
   output logic [DATA_W-1:0]        MemDB_out,
   output logic                     MemDB_oe,
   input  logic [DATA_W-1:0]        MemDB_in
);

   localparam int IDX_W = idx_width(NUM_CH);
   localparam int CNT_W = $clog2(max_int(ACCESS_CYCLES, RECOVERY_CYCLES) + 1);

   psdram_state_e     r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_last;
   logic [NUM_CH-1:0] r_gnt;
   logic              r_we;
   logic [NUM_CH-1:0] r_ack;
   logic [DATA_W-1:0] r_rdata;
   logic              r_busy;
   logic              r_oe_n;
   logic              r_wr_n;
   logic              r_ce_n;
   logic              r_lb_n;
   logic              r_ub_n;
   logic [ADDR_W-1:0] r_adr;
   logic [DATA_W-1:0] r_db_out;
   logic              r_db_oe;

   logic [NUM_CH-1:0] w_grant;
   logic              w_sel_we;
   logic [1:0]        w_sel_be;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [IDX_W-1:0]  w_sel_idx;

   rr_arbiter #(.N(NUM_CH)) u_rr (
      .req        (req),
      .last_grant (r_last),
      .prio_en    (PRIO_EN != 0),
      .grant      (w_grant)
   );

   // One-hot AND-OR mux of the winning channel's command.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_be    = 2'b00;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sel_we    |= we[i] & w_grant[i];
         w_sel_be    |= be_n[2*i +: 2] & {2{w_grant[i]}};
         w_sel_addr  |= addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_grant[i]}};
         w_sel_wdata |= wdata[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}};
         w_sel_idx   |= IDX_W'(i) & {IDX_W{w_grant[i]}};
      end
   end

   // Sequencer: strobes are produced as registers on the edge entering each state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_last   <= IDX_W'(NUM_CH - 1);
         r_gnt    <= '0;
         r_we     <= 1'b0;
         r_ack    <= '0;
         r_rdata  <= '0;
         r_busy   <= 1'b0;
         r_oe_n   <= 1'b1;
         r_wr_n   <= 1'b1;
         r_ce_n   <= 1'b1;
         r_lb_n   <= 1'b1;
         r_ub_n   <= 1'b1;
         r_adr    <= '0;
         r_db_out <= '0;
         r_db_oe  <= 1'b0;
      end else begin
         r_ack <= '0;
         case (r_state)
            ST_IDLE: begin
               if (req != '0) begin
                  r_state  <= ST_SETUP;
                  r_busy   <= 1'b1;
                  r_gnt    <= w_grant;
                  r_we     <= w_sel_we;
                  r_ce_n   <= 1'b0;
                  r_adr    <= w_sel_addr;
                  r_ub_n   <= w_sel_be[1];
                  r_lb_n   <= w_sel_be[0];
                  r_db_out <= w_sel_wdata;
                  r_db_oe  <= w_sel_we;
                  // A priority grant to channel 0 must not disturb the rotation.
                  if (!((PRIO_EN != 0) && w_grant[0])) begin
                     r_last <= w_sel_idx;
                  end
               end
            end
            ST_SETUP: begin
               r_state <= ST_ACCESS;
               r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
               r_oe_n  <= r_we;
               r_wr_n  <= ~r_we;
            end
            ST_ACCESS: begin
               if (r_cnt == '0) begin
                  r_state <= ST_RECOVER;
                  r_cnt   <= CNT_W'(RECOVERY_CYCLES - 1);
                  r_oe_n  <= 1'b1;
                  r_wr_n  <= 1'b1;
                  r_ce_n  <= 1'b1;
                  r_lb_n  <= 1'b1;
                  r_ub_n  <= 1'b1;
                  r_db_oe <= 1'b0;
                  r_ack   <= r_gnt;
                  if (!r_we) begin
                     r_rdata <= MemDB_in;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_RECOVER: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ack       = r_ack;
   assign rdata     = r_rdata;
   assign busy      = r_busy;
   assign MemOE     = r_oe_n;
   assign MemWR     = r_wr_n;
   assign RamCE     = r_ce_n;
   assign RamLB     = r_lb_n;
   assign RamUB     = r_ub_n;
   assign MemAdr    = r_adr;
   assign MemDB_out = r_db_out;
   assign MemDB_oe  = r_db_oe;

endmodule

// File: tb/tb_psdram_arbiter.sv
// Directed bench for psdram_arbiter: single read/write, early drop, reset
// mid-access, round-robin (3 ch, no priority) and priority (3 ch).
module tb_psdram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- DUT A: 2 channels, priority on ----------------
   logic        a_rst_n;
   logic [1:0]  a_req, a_we, a_ack;
   logic [3:0]  a_be_n;
   logic [45:0] a_addr;
   logic [31:0] a_wdata;
   logic [15:0] a_rdata, a_dbo, a_dbi;
   logic [22:0] a_adr;
   logic        a_busy, a_oe, a_wr, a_ce, a_lb, a_ub, a_dboe;
   logic [15:0] mem [16];

   psdram_arbiter dut_a (
      .clk(clk), .reset_n(a_rst_n), .req(a_req), .we(a_we), .be_n(a_be_n),
      .addr(a_addr), .wdata(a_wdata), .ack(a_ack), .rdata(a_rdata), .busy(a_busy),
      .MemOE(a_oe), .MemWR(a_wr), .RamCE(a_ce), .RamLB(a_lb), .RamUB(a_ub),
      .MemAdr(a_adr), .MemDB_out(a_dbo), .MemDB_oe(a_dboe), .MemDB_in(a_dbi)
   );

   // Memory model: 16 words selected by the low address bits, byte-writable.
   assign a_dbi = (!a_ce && !a_oe) ? mem[a_adr[3:0]] : 16'h0000;
   always @(posedge clk) begin
      if (!a_rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
         mem[4] <= 16'hBEEF;
         mem[5] <= 16'h3C3C;
      end else if (!a_ce && !a_wr && a_dboe) begin
         if (!a_lb) mem[a_adr[3:0]][7:0]  <= a_dbo[7:0];
         if (!a_ub) mem[a_adr[3:0]][15:8] <= a_dbo[15:8];
      end
   end

   // ---------------- DUT B (no priority) and C (priority), 3 channels ----------------
   logic        rst_n;
   logic [2:0]  b_req, b_ack, c_req, c_ack;
   logic [15:0] b_rdata, c_rdata, b_dbo, c_dbo;
   logic [22:0] b_adr, c_adr;
   logic        b_busy, b_oe, b_wr, b_ce, b_lb, b_ub, b_dboe;
   logic        c_busy, c_oe, c_wr, c_ce, c_lb, c_ub, c_dboe;

   psdram_arbiter #(.NUM_CH(3), .PRIO_EN(0)) dut_b (
      .clk(clk), .reset_n(rst_n), .req(b_req), .we(3'b000), .be_n(6'b000000),
      .addr(69'h0), .wdata(48'h0), .ack(b_ack), .rdata(b_rdata), .busy(b_busy),
      .MemOE(b_oe), .MemWR(b_wr), .RamCE(b_ce), .RamLB(b_lb), .RamUB(b_ub),
      .MemAdr(b_adr), .MemDB_out(b_dbo), .MemDB_oe(b_dboe), .MemDB_in(16'h0000)
   );

   psdram_arbiter #(.NUM_CH(3), .PRIO_EN(1)) dut_c (
      .clk(clk), .reset_n(rst_n), .req(c_req), .we(3'b000), .be_n(6'b000000),
      .addr(69'h0), .wdata(48'h0), .ack(c_ack), .rdata(c_rdata), .busy(c_busy),
      .MemOE(c_oe), .MemWR(c_wr), .RamCE(c_ce), .RamLB(c_lb), .RamUB(c_ub),
      .MemAdr(c_adr), .MemDB_out(c_dbo), .MemDB_oe(c_dboe), .MemDB_in(16'h0000)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Statistics gathered by run_a over a window of cycles.
   int          oe_lo, wr_lo, ce_lo, dboe_hi, busy_hi, n_ack;
   int          ack_cyc [8];
   logic [31:0] ack_val [8];
   logic [15:0] ack_rd  [8];
   logic [22:0] adr_c1;
   logic [15:0] dbo_c1;
   logic        lb_c5, ub_c5;

   // Runs DUT A for ncyc cycles after the request edge; sampled at each negedge.
   task automatic run_a(input int ncyc, input int drop_at);
      oe_lo = 0; wr_lo = 0; ce_lo = 0; dboe_hi = 0; busy_hi = 0; n_ack = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!a_oe)  oe_lo++;
         if (!a_wr)  wr_lo++;
         if (!a_ce)  ce_lo++;
         if (a_dboe) dboe_hi++;
         if (a_busy) busy_hi++;
         if (c == 1) begin adr_c1 = a_adr; dbo_c1 = a_dbo; end
         if (c == 5) begin lb_c5 = a_lb; ub_c5 = a_ub; end
         if (a_ack != 2'b00) begin
            if (n_ack < 8) begin
               ack_val[n_ack] = 32'(a_ack);
               ack_cyc[n_ack] = c;
               ack_rd[n_ack]  = a_rdata;
            end
            n_ack++;
            a_req = 2'b00;
         end
         if (c == drop_at) a_req = 2'b00;
      end
   endtask

   // Collects up to 8 acks from DUT B or C (sel 0 = B, 1 = C) for ncyc cycles.
   task automatic run_bc(input int sel, input int ncyc);
      logic [2:0] a;
      n_ack = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         @(negedge clk);
         a = (sel == 0) ? b_ack : c_ack;
         if (sel == 1 && c == 14) c_req[0] = 1'b1;
         if (a != 3'b000) begin
            if (n_ack < 8) begin
               ack_val[n_ack] = 32'(a);
               ack_cyc[n_ack] = c;
            end
            n_ack++;
            if (sel == 1 && a[0]) c_req[0] = 1'b0;
         end
      end
   endtask

   logic [2:0]  exp_c [5];

   initial begin
      a_rst_n = 1'b0; rst_n = 1'b0;
      a_req = 2'b00; a_we = 2'b00; a_be_n = 4'b0000; a_addr = 46'h0; a_wdata = 32'h0;
      b_req = 3'b000; c_req = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_strobes", 32'({a_ce, a_oe, a_wr, a_lb, a_ub, a_dboe, a_busy}), 32'h7C);
      check("reset_adr",   32'(a_adr),   32'h0);
      check("reset_dbo",   32'(a_dbo),   32'h0);
      check("reset_ack",   32'(a_ack),   32'h0);
      check("reset_rdata", 32'(a_rdata), 32'h0);
      a_rst_n = 1'b1; rst_n = 1'b1;

      // Single read by ch1 at word 0x001234.
      @(posedge clk); #1;
      a_addr = {23'h001234, 23'h000000}; a_we = 2'b00; a_req = 2'b10;
      run_a(12, 0);
      check("rd_oe_low",  32'(oe_lo), 32'd7);
      check("rd_wr_low",  32'(wr_lo), 32'd0);
      check("rd_ce_low",  32'(ce_lo), 32'd8);
      check("rd_busy",    32'(busy_hi), 32'd9);
      check("rd_adr",     32'(adr_c1), 32'h001234);
      check("rd_nack",    32'(n_ack), 32'd1);
      check("rd_ack_cyc", 32'(ack_cyc[0]), 32'd9);
      check("rd_ack_val", ack_val[0], 32'h2);
      check("rd_rdata",   32'(ack_rd[0]), 32'hBEEF);

      // Single write by ch0: 0xA5A5, low byte only, to word 5 (preset 0x3C3C).
      @(posedge clk); #1;
      a_addr = {23'h000000, 23'h000055}; a_wdata = {16'h0000, 16'hA5A5};
      a_be_n = {2'b11, 2'b10}; a_we = 2'b01; a_req = 2'b01;
      run_a(12, 0);
      check("wr_wr_low",  32'(wr_lo), 32'd7);
      check("wr_oe_low",  32'(oe_lo), 32'd0);
      check("wr_dboe",    32'(dboe_hi), 32'd8);
      check("wr_dbo",     32'(dbo_c1), 32'hA5A5);
      check("wr_lb_ub",   32'({ub_c5, lb_c5}), 32'h2);
      check("wr_ack_cyc", 32'(ack_cyc[0]), 32'd9);
      check("wr_ack_val", ack_val[0], 32'h1);
      check("wr_mem",     32'(mem[5]), 32'h3CA5);

      // ch1 drops its request one cycle after grant.
      @(posedge clk); #1;
      a_addr = {23'h001234, 23'h000000}; a_we = 2'b00; a_be_n = 4'b0000; a_req = 2'b10;
      run_a(25, 2);
      check("drop_nack",    32'(n_ack), 32'd1);
      check("drop_ack_cyc", 32'(ack_cyc[0]), 32'd9);
      check("drop_ack_val", ack_val[0], 32'h2);
      check("drop_busy",    32'(busy_hi), 32'd9);

      // Reset during the third ACCESS cycle of a ch1 read.
      @(posedge clk); #1;
      a_req = 2'b10;
      run_a(4, 0);
      a_rst_n = 1'b0;
      #1;
      check("rst_mid_strobes", 32'({a_ce, a_oe, a_wr, a_dboe, a_busy}), 32'h1C);
      check("rst_mid_nack",    32'(n_ack), 32'd0);
      a_req = 2'b11;
      repeat (2) @(posedge clk);
      check("rst_hold_ack", 32'(a_ack), 32'h0);
      @(negedge clk);
      a_rst_n = 1'b1;
      run_a(15, 0);
      check("rst_first_ack", ack_val[0], 32'h1);

      // Round-robin, three channels all requesting.
      @(posedge clk); #1;
      b_req = 3'b111;
      run_bc(0, 62);
      b_req = 3'b000;
      check("rr_nack", 32'(n_ack), 32'd6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rr_val%0d", k), ack_val[k], 32'(3'b001 << (k % 3)));
         check($sformatf("rr_cyc%0d", k), 32'(ack_cyc[k]), 32'(9 + 10 * k));
      end
      check("rr_rdata", 32'(b_rdata), 32'h0);

      // Priority: ch1/ch2 saturating, ch0 requests once during the ch2 access.
      exp_c[0] = 3'b010; exp_c[1] = 3'b100; exp_c[2] = 3'b001;
      exp_c[3] = 3'b010; exp_c[4] = 3'b100;
      @(posedge clk); #1;
      c_req = 3'b110;
      run_bc(1, 52);
      c_req = 3'b000;
      check("pr_nack", 32'(n_ack), 32'd5);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("pr_val%0d", k), ack_val[k], 32'(exp_c[k]));
         check($sformatf("pr_cyc%0d", k), 32'(ack_cyc[k]), 32'(9 + 10 * k));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
